// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO store responder: page offsets, STATUS bit positions, decode enum.
package mmio_pkg;

    localparam logic [7:0] OFS_TXDATA = 8'h00;
    localparam logic [7:0] OFS_STATUS = 8'h04;
    localparam logic [7:0] OFS_TOHOST = 8'h08;
    localparam logic [7:0] OFS_CYCLES = 8'h0C;

    localparam int unsigned ST_DONE_BIT  = 31;
    localparam int unsigned ST_OVF_BIT   = 15;
    localparam int unsigned ST_FULL_BIT  = 14;
    localparam int unsigned ST_EMPTY_BIT = 13;

    typedef enum logic [2:0] {
        DEC_RAM,
        DEC_TX,
        DEC_STAT,
        DEC_HOST,
        DEC_CYC,
        DEC_NONE
    } dec_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop when full; head word visible on dout, zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop_c  = pop & ~empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push_c = push & (~full | do_pop_c);
    assign dout      = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_store_responder.sv
// Data-port responder: word RAM plus MMIO page (TX FIFO, STATUS, sticky TOHOST).
// Optional cycle counter at offset 0x0C enabled by defining MMIO_CYCLES_EN.
module mmio_store_responder
    import mmio_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        done,
    output logic [31:0] done_code,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    dec_e          dec;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram [RAM_WORDS];
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_adr;

    assign unused_adr = ^DataAdr[1:0];
    assign ram_idx    = DataAdr[2 +: AW];

    // Address decode: anything outside the MMIO page is RAM (index wraps).
    always_comb begin
        dec = DEC_RAM;
        if (DataAdr[31:8] == MMIO_BASE[31:8]) begin
            case ({DataAdr[7:2], 2'b00})
                OFS_TXDATA: dec = DEC_TX;
                OFS_STATUS: dec = DEC_STAT;
                OFS_TOHOST: dec = DEC_HOST;
`ifdef MMIO_CYCLES_EN
                OFS_CYCLES: dec = DEC_CYC;
`endif
                default:    dec = DEC_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (MemWrite && (dec == DEC_RAM)) begin
            ram[ram_idx] <= WriteData;
        end
    end

    assign push     = MemWrite && (dec == DEC_TX);
    assign pop      = tx_valid & tx_ready;
    assign tx_valid = ~fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_txfifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .din   (WriteData[7:0]),
        .pop   (pop),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky flags: only the first TOHOST store is recorded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done      <= 1'b0;
            done_code <= '0;
            overflow  <= 1'b0;
        end else begin
            if (MemWrite && (dec == DEC_HOST) && !done) begin
                done      <= 1'b1;
                done_code <= WriteData;
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef MMIO_CYCLES_EN
    logic [31:0] cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
        end else if (MemWrite && (dec == DEC_CYC)) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

    always_comb begin
        status                = '0;
        status[ST_DONE_BIT]   = done;
        status[ST_OVF_BIT]    = overflow;
        status[ST_FULL_BIT]   = fifo_full;
        status[ST_EMPTY_BIT]  = fifo_empty;
        status[7:0]           = 8'(fifo_count);
    end

    always_comb begin
        ReadData = '0;
        case (dec)
            DEC_RAM:  ReadData = ram[ram_idx];
            DEC_STAT: ReadData = status;
`ifdef MMIO_CYCLES_EN
            DEC_CYC:  ReadData = cycles;
`endif
            default:  ReadData = '0;
        endcase
    end

endmodule
